// File: rtl/alu_loader_pkg.sv
// Shared constants for the ALU operand loader: default widths, button
// indices and the encoding of the sequential-mode FSM state.
package alu_loader_pkg;

   localparam int NB_DATA_DEF      = 8;
   localparam int NB_OP_DEF        = 6;
   localparam int DEBOUNCE_CYC_DEF = 4;

   localparam int NB_BTN   = 3;
   localparam int NB_STATE = 2;

   // Button positions on i_btn / o_loaded
   localparam int BTN_A  = 0;
   localparam int BTN_B  = 1;
   localparam int BTN_OP = 2;

   localparam logic [NB_BTN-1:0] LOADED_ALL = '1;

   // Sequential-mode FSM encoding, also shown on the LEDs
   localparam logic [NB_STATE-1:0] S_A    = 2'd0;
   localparam logic [NB_STATE-1:0] S_B    = 2'd1;
   localparam logic [NB_STATE-1:0] S_OP   = 2'd2;
   localparam logic [NB_STATE-1:0] S_DONE = 2'd3;

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: two-flop synchroniser, stability counter and
// rising-edge detector producing a one-cycle press pulse.
// A level change is accepted only after DEBOUNCE_CYC consecutive synced
// samples that disagree with the current debounced level; any agreeing
// sample restarts the count, so short glitches never reach o_level.
module btn_debounce
   import alu_loader_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_level,
   output logic o_press
);

   localparam int NB_CNT = (DEBOUNCE_CYC < 1) ? 1 : $clog2(DEBOUNCE_CYC + 1);
   localparam logic [NB_CNT-1:0] CNT_TERM = NB_CNT'(DEBOUNCE_CYC);

   logic              r_sync1;
   logic              r_sync2;
   logic [NB_CNT-1:0] r_cnt;
   logic              r_level;
   logic              r_level_d;
   logic              r_press;

   logic [NB_CNT-1:0] w_cnt_inc;
   logic              w_differs;

   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_differs = (r_sync2 != r_level);

   // Bring the raw asynchronous button into the clock domain
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
      end
   end

   // Count consecutive disagreeing samples; flip the level on terminal count
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
      end else if (!w_differs) begin
         r_cnt   <= '0;
      end else if (w_cnt_inc == CNT_TERM) begin
         r_cnt   <= '0;
         r_level <= r_sync2;
      end else begin
         r_cnt   <= w_cnt_inc;
      end
   end

   // Registered rising-edge detect on the debounced level
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_level_d <= 1'b0;
         r_press   <= 1'b0;
      end else begin
         r_level_d <= r_level;
         r_press   <= r_level & ~r_level_d;
      end
   end

   assign o_level = r_level;
   assign o_press = r_press;

endmodule

// File: rtl/alu_operand_loader.sv
// ALU operand front end: captures operand A, operand B and the opcode from
// the switch bus on debounced button presses and flags a complete set.
//
// Sequential-mode FSM (direct mode parks in S_A):
//   state  | meaning
//   S_A    | waiting for C press to capture operand A
//   S_B    | waiting for C press to capture operand B
//   S_OP   | waiting for C press to capture the opcode
//   S_DONE | full set captured; emit o_valid, clear flags, back to S_A
module alu_operand_loader
   import alu_loader_pkg::*;
#(
   parameter int NB_DATA      = NB_DATA_DEF,
   parameter int NB_OP        = NB_OP_DEF,
   parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [NB_DATA-1:0]  i_sw,
   input  logic [NB_BTN-1:0]   i_btn,
   input  logic                i_mode,
   output logic [NB_DATA-1:0]  o_data_a,
   output logic [NB_DATA-1:0]  o_data_b,
   output logic [NB_OP-1:0]    o_op,
   output logic [NB_BTN-1:0]   o_loaded,
   output logic [NB_STATE-1:0] o_state,
   output logic                o_valid
);

   logic [NB_DATA-1:0]  r_data_a;
   logic [NB_DATA-1:0]  r_data_b;
   logic [NB_OP-1:0]    r_op;
   logic [NB_BTN-1:0]   r_loaded;
   logic [NB_STATE-1:0] r_state;
   logic                r_mode;
   logic                r_valid;

   logic [NB_BTN-1:0]   w_press;
   // Debounced levels are only observed for probing; the loader acts on presses
   logic [NB_BTN-1:0]   w_level_unused;
   logic                w_mode_chg;
   logic                w_load_a;
   logic                w_load_b;
   logic                w_load_op;
   logic [NB_BTN-1:0]   w_load_vec;
   logic                w_full;
   logic [NB_STATE-1:0] w_state_nxt;

   for (genvar g = 0; g < NB_BTN; g++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_debounce (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_btn   (i_btn[g]),
         .o_level (w_level_unused[g]),
         .o_press (w_press[g])
      );
   end

   // A mode flip aborts whatever is in flight; presses in that cycle are lost
   assign w_mode_chg = (i_mode != r_mode);

   // Decode which operand register captures the switches this cycle
   always_comb begin
      w_load_a  = 1'b0;
      w_load_b  = 1'b0;
      w_load_op = 1'b0;
      if (!w_mode_chg) begin
         if (r_mode) begin
            w_load_a  = (r_state == S_A)  && w_press[BTN_B];
            w_load_b  = (r_state == S_B)  && w_press[BTN_B];
            w_load_op = (r_state == S_OP) && w_press[BTN_B];
         end else begin
            w_load_a  = w_press[BTN_A];
            w_load_b  = w_press[BTN_B];
            w_load_op = w_press[BTN_OP];
         end
      end
   end

   assign w_load_vec = {w_load_op, w_load_b, w_load_a};

   // In sequential mode all flags are set exactly while sitting in S_DONE,
   // so one completion rule serves both modes.
   assign w_full = !w_mode_chg && (r_loaded == LOADED_ALL);

   // Sequential-mode next state; direct mode and mode flips hold S_A
   always_comb begin
      w_state_nxt = r_state;
      if (w_mode_chg || !r_mode) begin
         w_state_nxt = S_A;
      end else begin
         case (r_state)
            S_A:     if (w_load_a)  w_state_nxt = S_B;
            S_B:     if (w_load_b)  w_state_nxt = S_OP;
            S_OP:    if (w_load_op) w_state_nxt = S_DONE;
            S_DONE:                 w_state_nxt = S_A;
            default:                w_state_nxt = S_A;
         endcase
      end
   end

   // FSM state and registered copy of the mode input
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= S_A;
         r_mode  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_mode  <= i_mode;
      end
   end

   // Operand registers only move on a load, so the ALU sees stable values
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_data_a <= '0;
         r_data_b <= '0;
         r_op     <= '0;
      end else begin
         if (w_load_a)  r_data_a <= i_sw;
         if (w_load_b)  r_data_b <= i_sw;
         if (w_load_op) r_op     <= i_sw[NB_OP-1:0];
      end
   end

   // Sticky loaded flags and the one-cycle completion pulse.
   // On completion the flags restart from any load landing in the same
   // cycle so a direct-mode press is never silently forgotten.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_loaded <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= w_full;
         if (w_mode_chg) begin
            r_loaded <= '0;
         end else if (w_full) begin
            r_loaded <= w_load_vec;
         end else begin
            r_loaded <= r_loaded | w_load_vec;
         end
      end
   end

   assign o_data_a = r_data_a;
   assign o_data_b = r_data_b;
   assign o_op     = r_op;
   assign o_loaded = r_loaded;
   assign o_state  = r_state;
   assign o_valid  = r_valid;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: directed scenarios plus a randomized run
// checked cycle by cycle against a behavioural model of the loader.
module tb_alu_operand_loader;
   import alu_loader_pkg::*;

   localparam int NB_D = 8;
   localparam int NB_O = 6;
   localparam int DEB  = 4;
   localparam int HL   = DEB + 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [NB_D-1:0] sw;
   logic [2:0]      btn;
   logic            mode;
   logic [NB_D-1:0] o_data_a;
   logic [NB_D-1:0] o_data_b;
   logic [NB_O-1:0] o_op;
   logic [2:0]      o_loaded;
   logic [1:0]      o_state;
   logic            o_valid;

   int n_cmp = 0;
   int n_err = 0;
   int n_valid = 0;

   alu_operand_loader #(
      .NB_DATA      (NB_D),
      .NB_OP        (NB_O),
      .DEBOUNCE_CYC (DEB)
   ) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_sw     (sw),
      .i_btn    (btn),
      .i_mode   (mode),
      .o_data_a (o_data_a),
      .o_data_b (o_data_b),
      .o_op     (o_op),
      .o_loaded (o_loaded),
      .o_state  (o_state),
      .o_valid  (o_valid)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   // A button level flips once the last DEB synchronised samples (raw
   // samples two edges old) all disagree with it; the press pulse follows
   // one edge later and the operand load one edge after that.
   bit              hist [3][HL];
   bit              m_lvl [3];
   bit              m_rose [3];
   bit              m_pq [3];
   logic [NB_D-1:0] m_a, m_b;
   logic [NB_O-1:0] m_op;
   logic [2:0]      m_loaded;
   int              m_step;
   bit              m_mode;
   bit              m_valid;
   bit              m_nv;
   bit              m_all_diff;

   always @(posedge clk) begin
      if (rst !== 1'b1) begin
         for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < HL; i++) hist[b][i] = 1'b0;
            m_lvl[b] = 1'b0; m_rose[b] = 1'b0; m_pq[b] = 1'b0;
         end
         m_a = '0; m_b = '0; m_op = '0; m_loaded = '0;
         m_step = 0; m_mode = 1'b0; m_valid = 1'b0;
      end else begin
         m_nv = 1'b0;
         if (mode !== m_mode) begin
            m_mode = mode; m_loaded = '0; m_step = 0;
         end else if (!m_mode) begin
            if (m_loaded == 3'b111) begin m_nv = 1'b1; m_loaded = '0; end
            if (m_pq[0]) begin m_a  = sw;         m_loaded[0] = 1'b1; end
            if (m_pq[1]) begin m_b  = sw;         m_loaded[1] = 1'b1; end
            if (m_pq[2]) begin m_op = sw[NB_O-1:0]; m_loaded[2] = 1'b1; end
            m_step = 0;
         end else begin
            if (m_step == 3) begin
               m_nv = 1'b1; m_loaded = '0; m_step = 0;
            end else if (m_pq[1]) begin
               case (m_step)
                  0:       m_a  = sw;
                  1:       m_b  = sw;
                  default: m_op = sw[NB_O-1:0];
               endcase
               m_loaded[m_step] = 1'b1;
               m_step++;
            end
         end
         m_valid = m_nv;
         for (int b = 0; b < 3; b++) begin
            for (int i = HL - 1; i > 0; i--) hist[b][i] = hist[b][i-1];
            hist[b][0] = btn[b];
            m_pq[b]   = m_rose[b];
            m_rose[b] = 1'b0;
            m_all_diff = 1'b1;
            for (int i = 2; i < HL; i++) if (hist[b][i] == m_lvl[b]) m_all_diff = 1'b0;
            if (m_all_diff) begin
               m_lvl[b]  = ~m_lvl[b];
               m_rose[b] = m_lvl[b];
            end
         end
      end
   end

   // Monitors: count valid pulses and log LED state transitions
   bit   log_state = 1'b0;
   logic [1:0] last_state = 2'd0;
   int   state_log[$];

   always @(negedge clk) begin
      if (o_valid === 1'b1) n_valid++;
      if (log_state && o_state !== last_state) state_log.push_back(int'(o_state));
      last_state = o_state;
   end

   // Press button b with switches at val for hold cycles, then let it settle
   task automatic press_btn(input int b, input logic [NB_D-1:0] val, input int hold);
      sw = val;
      btn[b] = 1'b1;
      repeat (hold) @(negedge clk);
      btn[b] = 1'b0;
      repeat (14) @(negedge clk);
   endtask

   task automatic test_reset();
      int v0;
      rst = 1'b0; btn = '0; sw = '0; mode = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      v0 = n_valid;
      repeat (50) @(negedge clk);
      n_cmp++; if (o_data_a !== 8'h00) begin n_err++; $display("FAIL reset_a: got %h want 00", o_data_a); end
      n_cmp++; if (o_data_b !== 8'h00) begin n_err++; $display("FAIL reset_b: got %h want 00", o_data_b); end
      n_cmp++; if (o_op !== 6'h00) begin n_err++; $display("FAIL reset_op: got %h want 00", o_op); end
      n_cmp++; if (o_loaded !== 3'b000) begin n_err++; $display("FAIL reset_loaded: got %b want 000", o_loaded); end
      n_cmp++; if (o_state !== S_A) begin n_err++; $display("FAIL reset_state: got %0d want 0", o_state); end
      n_cmp++; if (n_valid !== v0) begin n_err++; $display("FAIL reset_valid: got %0d pulses want 0", n_valid - v0); end
   endtask

   task automatic test_direct();
      int lidx, vidx, v0;
      mode = 1'b0;
      v0 = n_valid;
      press_btn(BTN_A, 8'h05, 10);
      press_btn(BTN_B, 8'h02, 10);
      sw = 8'h20; btn[BTN_OP] = 1'b1;
      lidx = -1; vidx = -1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (k == 9) btn[BTN_OP] = 1'b0;
         if (lidx < 0 && o_loaded === 3'b111) lidx = k;
         if (vidx < 0 && o_valid === 1'b1) vidx = k;
      end
      n_cmp++; if (o_data_a !== 8'h05) begin n_err++; $display("FAIL direct_a: got %h want 05", o_data_a); end
      n_cmp++; if (o_data_b !== 8'h02) begin n_err++; $display("FAIL direct_b: got %h want 02", o_data_b); end
      n_cmp++; if (o_op !== 6'h20) begin n_err++; $display("FAIL direct_op: got %h want 20", o_op); end
      n_cmp++; if (lidx < 0 || vidx !== lidx + 1) begin n_err++; $display("FAIL direct_valid_timing: loaded at %0d valid at %0d want valid one cycle after loaded", lidx, vidx); end
      n_cmp++; if (o_loaded !== 3'b000) begin n_err++; $display("FAIL direct_loaded_clear: got %b want 000", o_loaded); end
      n_cmp++; if (n_valid - v0 !== 1) begin n_err++; $display("FAIL direct_valid_count: got %0d want 1", n_valid - v0); end
   endtask

   task automatic test_bounce();
      int lat;
      sw = 8'hAA;
      btn[BTN_A] = 1'b1; @(negedge clk);
      btn[BTN_A] = 1'b0; @(negedge clk);
      btn[BTN_A] = 1'b1; @(negedge clk);
      btn[BTN_A] = 1'b0;
      repeat (15) @(negedge clk);
      n_cmp++; if (o_data_a !== 8'h05) begin n_err++; $display("FAIL bounce_a: got %h want 05", o_data_a); end
      n_cmp++; if (o_loaded !== 3'b000) begin n_err++; $display("FAIL bounce_loaded: got %b want 000", o_loaded); end
      sw = 8'h3c; btn[BTN_A] = 1'b1;
      lat = -1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (lat < 0 && o_data_a === 8'h3c) lat = k;
         if (k == DEB + 1) btn[BTN_A] = 1'b0;
      end
      @(negedge clk);
      repeat (10) @(negedge clk);
      n_cmp++; if (lat !== DEB + 3) begin n_err++; $display("FAIL bounce_latency: got %0d edges want %0d", lat, DEB + 3); end
      n_cmp++; if (o_data_a !== 8'h3c) begin n_err++; $display("FAIL bounce_hold_a: got %h want 3c", o_data_a); end
      n_cmp++; if (o_loaded !== 3'b001) begin n_err++; $display("FAIL bounce_hold_loaded: got %b want 001", o_loaded); end
   endtask

   task automatic test_sequential();
      int v0;
      bit seq_ok;
      mode = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (o_loaded !== 3'b000) begin n_err++; $display("FAIL seq_entry_loaded: got %b want 000", o_loaded); end
      state_log.delete();
      last_state = o_state;
      log_state = 1'b1;
      v0 = n_valid;
      press_btn(BTN_B, 8'h0f, 10);
      n_cmp++; if (o_state !== S_B) begin n_err++; $display("FAIL seq_state_b: got %0d want 1", o_state); end
      press_btn(BTN_OP, 8'h99, 10);
      press_btn(BTN_A, 8'h99, 10);
      n_cmp++; if (o_state !== S_B || o_data_a !== 8'h0f || o_op !== 6'h20) begin
         n_err++; $display("FAIL seq_ignore_lr: state %0d a %h op %h want 1 0f 20", o_state, o_data_a, o_op);
      end
      press_btn(BTN_B, 8'hf0, 10);
      press_btn(BTN_B, 8'h25, 10);
      log_state = 1'b0;
      n_cmp++; if (o_data_a !== 8'h0f) begin n_err++; $display("FAIL seq_a: got %h want 0f", o_data_a); end
      n_cmp++; if (o_data_b !== 8'hf0) begin n_err++; $display("FAIL seq_b: got %h want f0", o_data_b); end
      n_cmp++; if (o_op !== 6'h25) begin n_err++; $display("FAIL seq_op: got %h want 25", o_op); end
      seq_ok = (state_log.size() == 4);
      if (seq_ok) seq_ok = (state_log[0] == 1 && state_log[1] == 2 && state_log[2] == 3 && state_log[3] == 0);
      n_cmp++; if (!seq_ok) begin n_err++; $display("FAIL seq_state_walk: got %0d transitions want 1,2,3,0", state_log.size()); end
      n_cmp++; if (n_valid - v0 !== 1) begin n_err++; $display("FAIL seq_valid_count: got %0d want 1", n_valid - v0); end
   endtask

   task automatic test_mode_switch();
      int v0;
      press_btn(BTN_B, 8'h11, 10);
      n_cmp++; if (o_state !== S_B) begin n_err++; $display("FAIL modesw_pre_state: got %0d want 1", o_state); end
      v0 = n_valid;
      mode = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (o_state !== S_A) begin n_err++; $display("FAIL modesw_state: got %0d want 0", o_state); end
      n_cmp++; if (o_loaded !== 3'b000) begin n_err++; $display("FAIL modesw_loaded: got %b want 000", o_loaded); end
      n_cmp++; if (o_data_a !== 8'h11 || o_data_b !== 8'hf0 || o_op !== 6'h25) begin
         n_err++; $display("FAIL modesw_retain: a %h b %h op %h want 11 f0 25", o_data_a, o_data_b, o_op);
      end
      n_cmp++; if (n_valid !== v0) begin n_err++; $display("FAIL modesw_valid: got %0d pulses want 0", n_valid - v0); end
   endtask

   task automatic test_reset_mid();
      mode = 1'b1;
      repeat (2) @(negedge clk);
      press_btn(BTN_B, 8'h31, 10);
      press_btn(BTN_B, 8'h32, 10);
      n_cmp++; if (o_state !== S_OP) begin n_err++; $display("FAIL rstmid_pre_state: got %0d want 2", o_state); end
      sw = 8'h77; btn[BTN_B] = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (o_data_a !== 8'h00 || o_data_b !== 8'h00 || o_op !== 6'h00) begin
         n_err++; $display("FAIL rstmid_data: a %h b %h op %h want 00 00 00", o_data_a, o_data_b, o_op);
      end
      n_cmp++; if (o_loaded !== 3'b000 || o_state !== S_A || o_valid !== 1'b0) begin
         n_err++; $display("FAIL rstmid_ctrl: loaded %b state %0d valid %b want 000 0 0", o_loaded, o_state, o_valid);
      end
      rst = 1'b1;
      repeat (10) @(negedge clk);
      btn[BTN_B] = 1'b0;
      repeat (14) @(negedge clk);
      n_cmp++; if (o_data_a !== 8'h77) begin n_err++; $display("FAIL rstmid_new_a: got %h want 77", o_data_a); end
      n_cmp++; if (o_state !== S_B || o_loaded !== 3'b001) begin
         n_err++; $display("FAIL rstmid_new_state: state %0d loaded %b want 1 001", o_state, o_loaded);
      end
   endtask

   task automatic test_random();
      int hold[3];
      for (int b = 0; b < 3; b++) hold[b] = 0;
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
         if ($urandom_range(0, 399) == 0) mode = ~mode;
         if ($urandom_range(0, 7) == 0) sw = NB_D'($urandom);
         for (int b = 0; b < 3; b++) begin
            if (hold[b] > 0) hold[b]--;
            else if ($urandom_range(0, 5) == 0) begin
               btn[b]  = ~btn[b];
               hold[b] = $urandom_range(0, 11);
            end
         end
         @(negedge clk);
         n_cmp++; if (o_data_a !== m_a) begin n_err++; $display("FAIL rnd_a cycle %0d: got %h want %h", c, o_data_a, m_a); end
         n_cmp++; if (o_data_b !== m_b) begin n_err++; $display("FAIL rnd_b cycle %0d: got %h want %h", c, o_data_b, m_b); end
         n_cmp++; if (o_op !== m_op) begin n_err++; $display("FAIL rnd_op cycle %0d: got %h want %h", c, o_op, m_op); end
         n_cmp++; if (o_loaded !== m_loaded) begin n_err++; $display("FAIL rnd_loaded cycle %0d: got %b want %b", c, o_loaded, m_loaded); end
         n_cmp++; if (o_state !== 2'(m_mode ? m_step : 0)) begin n_err++; $display("FAIL rnd_state cycle %0d: got %0d want %0d", c, o_state, m_mode ? m_step : 0); end
         n_cmp++; if (o_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid cycle %0d: got %b want %b", c, o_valid, m_valid); end
      end
   endtask

   initial begin
      rst = 1'b0; btn = '0; sw = '0; mode = 1'b0;
      test_reset();
      test_direct();
      test_bounce();
      test_sequential();
      test_mode_switch();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached after %0d compares", n_cmp);
      $fatal(1, "time limit");
   end

endmodule
